// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO of fetched {pc, instr}; slot 0 is always the head, so
// it keeps the last presented entry when the buffer drains or is flushed.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

    fetch_entry_t e0, e1;
    logic         pop_ok, push_ok;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign pop_ok  = pop & !empty;
    assign push_ok = push & (!full | pop_ok);
    assign head    = e0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            e0    <= '{pc: '0, instr: NOP_INSTR};
            e1    <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b11: begin
                    if (full) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                2'b10: begin
                    if (empty) e0 <= din;
                    else       e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (full) e0 <= e1;
                    count <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single outstanding memory request, and credit-based issue
// into a two-entry buffer that feeds decode over valid/ready.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_read_en,
    input  logic [31:0]     imem_data_out,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr
);

    logic [PC_W-1:0] pc, req_pc;
    logic            inflight;
    logic [1:0]      buf_count;
    logic            buf_empty, buf_full;
    logic            deq, credit_ok, issue, capture, push, pop;
    fetch_entry_t    buf_head;

    assign deq       = if_valid & if_ready;
    assign credit_ok = ({1'b0, buf_count} + {2'b00, inflight}) < 3'd2;
    // Gated by reset so the strobe is low for the whole reset interval.
    assign issue     = reset & !redirect_valid & (credit_ok | deq);
    assign capture   = inflight & !redirect_valid;
    assign pop       = deq & !redirect_valid;
    assign push      = capture & (!buf_full | pop);

    assign imem_addr    = pc;
    assign imem_read_en = issue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect_valid) begin
                pc <= redirect_pc & ~32'd3;
            end else if (issue) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
        end
    end

    fetch_buffer u_buf (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ('{pc: req_pc, instr: imem_data_out}),
        .count (buf_count),
        .head  (buf_head),
        .empty (buf_empty),
        .full  (buf_full)
    );

    assign if_valid = !buf_empty;
    assign if_pc    = buf_head.pc;
    assign if_instr = buf_head.instr;

endmodule
